// File: rtl/calc_resp_checker.sv
// Response checker for the calc DUV family: snoops request/response buses, predicts each
// result and checks responses in order per port. Port 1 sits in the most-significant slice.
module calc_resp_checker #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
  input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
  input  logic [2*NUM_PORTS-1:0]      out_resp,
  input  logic [DATA_W*NUM_PORTS-1:0] out_data,
  output logic [NUM_PORTS-1:0]        chk_pass,
  output logic [NUM_PORTS-1:0]        chk_fail,
  output logic [NUM_PORTS-1:0]        chk_timeout,
  output logic [NUM_PORTS-1:0]        chk_ovf,
  output logic [CNT_W-1:0]            pass_count,
  output logic [CNT_W-1:0]            fail_count,
  output logic                        busy
);
  localparam int unsigned ShW  = $clog2(DATA_W);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam int unsigned EntW = 2 + DATA_W;
  localparam int unsigned SumW = CNT_W + $clog2(NUM_PORTS + 1);

  localparam logic [3:0] CmdAdd = 4'd1;
  localparam logic [3:0] CmdSub = 4'd2;
  localparam logic [3:0] CmdShl = 4'd5;
  localparam logic [3:0] CmdShr = 4'd6;

  localparam logic [1:0] RespNone = 2'd0;
  localparam logic [1:0] RespOk   = 2'd1;
  localparam logic [1:0] RespOvf  = 2'd2;
  localparam logic [1:0] RespInv  = 2'd3;

  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StOp2} state_e;

  logic [NUM_PORTS-1:0] pass_d, fail_d, tout_d, busy_vec;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    localparam int unsigned S = NUM_PORTS - 1 - p;

    logic [3:0]        cmd;
    logic [DATA_W-1:0] din, rdata;
    logic [1:0]        rresp;

    assign cmd   = req_cmd_in[4*S +: 4];
    assign din   = req_data_in[DATA_W*S +: DATA_W];
    assign rresp = out_resp[2*S +: 2];
    assign rdata = out_data[DATA_W*S +: DATA_W];

    state_e            state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              pass_q, fail_q, tout_q, ovf_q, ovf_d;
    logic              pass_n, fail_n, tout_n;
    logic [EntW-1:0]   mem_q [DEPTH];
    logic [EntW-1:0]   exp_ent, head;
    logic [1:0]        head_resp;
    logic [DATA_W:0]   sum;
    logic              push_req, push, pop, empty, full;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CntW'(DEPTH));
    assign head      = mem_q[rd_ptr_q];
    assign head_resp = head[EntW-1 -: 2];
    assign push_req  = (state_q == StOp2);

    // In StOp2 the bus carries op2; the entry is built from it on the same edge.
    always_comb begin
      sum = {1'b0, op1_q} + {1'b0, din};
      case (cmd_q)
        CmdAdd:  exp_ent = sum[DATA_W] ? {RespOvf, {DATA_W{1'b0}}}
                                       : {RespOk, sum[DATA_W-1:0]};
        CmdSub:  exp_ent = (op1_q < din) ? {RespOvf, {DATA_W{1'b0}}}
                                         : {RespOk, op1_q - din};
        CmdShl:  exp_ent = {RespOk, op1_q << din[ShW-1:0]};
        CmdShr:  exp_ent = {RespOk, op1_q >> din[ShW-1:0]};
        default: exp_ent = {RespInv, {DATA_W{1'b0}}};
      endcase
    end

    always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      op1_d   = op1_q;
      tmo_d   = tmo_q;
      pop     = 1'b0;
      pass_n  = 1'b0;
      fail_n  = 1'b0;
      tout_n  = 1'b0;

      // A response wins over an expiry landing on the same edge.
      if (rresp != RespNone) begin
        tmo_d = '0;
        if (empty) begin
          fail_n = 1'b1;
        end else begin
          pop = 1'b1;
          if (rresp == head_resp && (head_resp != RespOk || rdata == head[DATA_W-1:0])) begin
            pass_n = 1'b1;
          end else begin
            fail_n = 1'b1;
          end
        end
      end else if (!empty) begin
        if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          tout_n = 1'b1;
          pop    = 1'b1;
          tmo_d  = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      push     = push_req && (!full || pop);
      ovf_d    = ovf_q | (push_req & full & ~pop);
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q + CntW'(push) - CntW'(pop);

      unique case (state_q)
        StIdle: begin
          if (cmd != 4'd0) begin
            state_d = StOp2;
            cmd_d   = cmd;
            op1_d   = din;
          end
        end
        StOp2:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        state_q  <= StIdle;
        cmd_q    <= '0;
        op1_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        tmo_q    <= '0;
        pass_q   <= 1'b0;
        fail_q   <= 1'b0;
        tout_q   <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cmd_q    <= cmd_d;
        op1_q    <= op1_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        tmo_q    <= tmo_d;
        pass_q   <= pass_n;
        fail_q   <= fail_n;
        tout_q   <= tout_n;
        ovf_q    <= ovf_d;
      end
    end

    always_ff @(posedge c_clk) begin
      if (push) begin
        mem_q[wr_ptr_q] <= exp_ent;
      end
    end

    assign pass_d[p]      = pass_n;
    assign fail_d[p]      = fail_n;
    assign tout_d[p]      = tout_n;
    assign chk_pass[p]    = pass_q;
    assign chk_fail[p]    = fail_q;
    assign chk_timeout[p] = tout_q;
    assign chk_ovf[p]     = ovf_q;
    assign busy_vec[p]    = !empty || (state_q == StOp2);
  end

  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [SumW-1:0]  pass_inc, fail_inc, pass_sum, fail_sum;

  always_comb begin
    pass_inc = '0;
    fail_inc = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      pass_inc = pass_inc + SumW'(pass_d[i]);
      fail_inc = fail_inc + SumW'(fail_d[i] | tout_d[i]);
    end
    pass_sum   = SumW'(pass_cnt_q) + pass_inc;
    fail_sum   = SumW'(fail_cnt_q) + fail_inc;
    pass_cnt_d = (pass_sum > SumW'(CntMax)) ? CntMax : pass_sum[CNT_W-1:0];
    fail_cnt_d = (fail_sum > SumW'(CntMax)) ? CntMax : fail_sum[CNT_W-1:0];
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_count = pass_cnt_q;
  assign fail_count = fail_cnt_q;
  assign busy       = |busy_vec;

endmodule

// File: tb/tb_calc_resp_checker.sv
// Bench for calc_resp_checker: directed scenarios then randomized traffic, scored against a
// transaction-level model that queues the expected pulse for each port.
module tb_calc_resp_checker;
  localparam int NP      = 4;
  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int CW      = 4;
  localparam int CntMax  = 15;

  logic              c_clk = 1'b0;
  logic              reset;
  logic [4*NP-1:0]   req_cmd_in;
  logic [DW*NP-1:0]  req_data_in;
  logic [2*NP-1:0]   out_resp;
  logic [DW*NP-1:0]  out_data;
  logic [NP-1:0]     chk_pass, chk_fail, chk_timeout, chk_ovf;
  logic [CW-1:0]     pass_count, fail_count;
  logic              busy;

  logic [3:0]    cmd_drv  [NP];
  logic [DW-1:0] dat_drv  [NP];
  logic [1:0]    resp_drv [NP];
  logic [DW-1:0] rdat_drv [NP];

  always #5 c_clk = ~c_clk;

  // Port 1 (index 0) occupies the most-significant slice of each bus.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      req_cmd_in[4*(NP-1-p) +: 4]   = cmd_drv[p];
      req_data_in[DW*(NP-1-p) +: DW] = dat_drv[p];
      out_resp[2*(NP-1-p) +: 2]     = resp_drv[p];
      out_data[DW*(NP-1-p) +: DW]   = rdat_drv[p];
    end
  end

  calc_resp_checker #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CW)
  ) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .chk_pass    (chk_pass),
    .chk_fail    (chk_fail),
    .chk_timeout (chk_timeout),
    .chk_ovf     (chk_ovf),
    .pass_count  (pass_count),
    .fail_count  (fail_count),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_cyc = 0;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0] kind;  // one-hot {timeout, fail, pass}
    int         cyc;
  } evt_t;

  logic [DW+1:0] expq [NP][$];
  evt_t          evq  [NP][$];
  bit            pend [NP];
  logic [3:0]    pcmd [NP];
  logic [DW-1:0] pop1 [NP];
  int            waitc [NP];
  logic [NP-1:0] m_ovf;
  int            m_pass, m_fail;
  bit            m_busy;

  function automatic logic [DW+1:0] ref_entry(input logic [3:0] c, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    logic [63:0] s;
    s = {32'd0, a} + {32'd0, b};
    case (c)
      4'd1:    return (s > 64'hFFFF_FFFF) ? {2'd2, 32'd0} : {2'd1, s[31:0]};
      4'd2:    return (a < b) ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5:    return {2'd1, a << (b % 32)};
      4'd6:    return {2'd1, a >> (b % 32)};
      default: return {2'd3, 32'd0};
    endcase
  endfunction

  function automatic evt_t mk_evt(input logic [2:0] k, input int c);
    evt_t e;
    e.kind = k;
    e.cyc  = c;
    return e;
  endfunction

  always @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        expq[p].delete();
        evq[p].delete();
        pend[p]  = 1'b0;
        waitc[p] = 0;
      end
      m_ovf  = '0;
      m_pass = 0;
      m_fail = 0;
      m_busy = 1'b0;
    end else begin
      int np, nf;
      logic [DW+1:0] h;
      np = 0;
      nf = 0;
      m_cyc++;
      for (int p = 0; p < NP; p++) begin
        if (resp_drv[p] != 2'd0) begin
          if (expq[p].size() == 0) begin
            evq[p].push_back(mk_evt(3'b010, m_cyc));
            nf++;
          end else begin
            h = expq[p].pop_front();
            waitc[p] = 0;
            if (resp_drv[p] == h[DW+1:DW] && (h[DW+1:DW] != 2'd1 || rdat_drv[p] == h[DW-1:0]))
            begin
              evq[p].push_back(mk_evt(3'b001, m_cyc));
              np++;
            end else begin
              evq[p].push_back(mk_evt(3'b010, m_cyc));
              nf++;
            end
          end
        end else if (expq[p].size() != 0) begin
          waitc[p]++;
          if (waitc[p] == TIMEOUT) begin
            void'(expq[p].pop_front());
            waitc[p] = 0;
            evq[p].push_back(mk_evt(3'b100, m_cyc));
            nf++;
          end
        end
        if (pend[p]) begin
          if (expq[p].size() < DEPTH) expq[p].push_back(ref_entry(pcmd[p], pop1[p], dat_drv[p]));
          else m_ovf[p] = 1'b1;
          pend[p] = 1'b0;
        end else if (cmd_drv[p] != 4'd0) begin
          pend[p] = 1'b1;
          pcmd[p] = cmd_drv[p];
          pop1[p] = dat_drv[p];
        end
      end
      m_pass = (m_pass + np > CntMax) ? CntMax : m_pass + np;
      m_fail = (m_fail + nf > CntMax) ? CntMax : m_fail + nf;
      m_busy = 1'b0;
      for (int p = 0; p < NP; p++) if (expq[p].size() != 0 || pend[p]) m_busy = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge c_clk) begin
    if (reset) begin
      logic [2:0] obs, expv;
      evt_t e;
      for (int p = 0; p < NP; p++) begin
        obs  = {chk_timeout[p], chk_fail[p], chk_pass[p]};
        expv = 3'b000;
        if (evq[p].size() != 0 && evq[p][0].cyc <= m_cyc) begin
          e    = evq[p].pop_front();
          expv = e.kind;
        end
        if (obs != 3'b000 || expv != 3'b000) check($sformatf("pulse_p%0d", p), obs, expv);
      end
      check("pass_count", pass_count, m_pass);
      check("fail_count", fail_count, m_fail);
      check("chk_ovf", chk_ovf, m_ovf);
      check("busy", busy, m_busy);
    end
  end

  // ---------------- stimulus ----------------
  bit ph [NP];

  task automatic req(input int p, input logic [3:0] c, input logic [DW-1:0] a,
                     input logic [DW-1:0] b);
    cmd_drv[p] = c;
    dat_drv[p] = a;
    @(negedge c_clk);
    cmd_drv[p] = 4'd0;
    dat_drv[p] = b;
    @(negedge c_clk);
    dat_drv[p] = '0;
  endtask

  task automatic resp1(input int p, input logic [1:0] r, input logic [DW-1:0] d);
    resp_drv[p] = r;
    rdat_drv[p] = d;
    @(negedge c_clk);
    resp_drv[p] = 2'd0;
    rdat_drv[p] = '0;
  endtask

  task automatic add_all(input int base);
    fork
      req(0, 4'd1, DW'(base), 1);
      req(1, 4'd1, DW'(base + 10), 2);
      req(2, 4'd1, DW'(base + 20), 3);
      req(3, 4'd1, DW'(base + 30), 4);
    join
    for (int p = 0; p < NP; p++) begin
      resp_drv[p] = 2'd1;
      rdat_drv[p] = DW'(base + 10 * p + p + 1);
    end
    @(negedge c_clk);
    for (int p = 0; p < NP; p++) begin
      resp_drv[p] = 2'd0;
      rdat_drv[p] = '0;
    end
  endtask

  function automatic logic [3:0] rand_cmd();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 4'd1;
    if (r < 5) return 4'd2;
    if (r < 7) return 4'd5;
    if (r < 9) return 4'd6;
    return 4'($urandom_range(1, 15));
  endfunction

  function automatic logic [DW-1:0] rand_opnd();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return DW'($urandom_range(0, 15));
    if (r == 1) return 32'hFFFF_FFF0 + DW'($urandom_range(0, 15));
    return DW'($urandom);
  endfunction

  task automatic rand_phase(input int cycles, input int req_pct, input int resp_pct,
                            input bit allow_new);
    logic [DW+1:0] h;
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (ph[p]) begin
          cmd_drv[p] = 4'($urandom);
          dat_drv[p] = rand_opnd();
          ph[p]      = 1'b0;
        end else if (allow_new && $urandom_range(0, 99) < req_pct) begin
          cmd_drv[p] = rand_cmd();
          dat_drv[p] = rand_opnd();
          ph[p]      = 1'b1;
        end else begin
          cmd_drv[p] = 4'd0;
          dat_drv[p] = DW'($urandom);
        end
        if (expq[p].size() != 0 && $urandom_range(0, 99) < resp_pct) begin
          h           = expq[p][0];
          resp_drv[p] = h[DW+1:DW];
          rdat_drv[p] = h[DW-1:0];
          if ($urandom_range(0, 9) == 0) rdat_drv[p] = rdat_drv[p] ^ (32'h1 << $urandom_range(0, 31));
          if ($urandom_range(0, 19) == 0) resp_drv[p] = 2'($urandom_range(1, 3));
        end else if (expq[p].size() == 0 && $urandom_range(0, 99) < 2) begin
          resp_drv[p] = 2'($urandom_range(1, 3));
          rdat_drv[p] = DW'($urandom);
        end else begin
          resp_drv[p] = 2'd0;
          rdat_drv[p] = DW'($urandom);
        end
      end
      @(negedge c_clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    for (int p = 0; p < NP; p++) begin
      cmd_drv[p]  = '0;
      dat_drv[p]  = '0;
      resp_drv[p] = '0;
      rdat_drv[p] = '0;
      ph[p]       = 1'b0;
    end
    reset = 1'b0;
    repeat (3) @(negedge c_clk);
    check("rst_pass_count", pass_count, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {chk_pass, chk_fail, chk_timeout, chk_ovf}, 0);
    reset = 1'b1;
    @(negedge c_clk);

    // Port 1 add, answered three cycles later
    req(0, 4'd1, 32'h2, 32'h3);
    repeat (2) @(negedge c_clk);
    resp1(0, 2'd1, 32'h5);
    check("a_pass_vec", chk_pass, 4'b0001);
    check("a_pass_count", pass_count, 1);

    // Port 2 add overflow answered as success
    req(1, 4'd1, 32'hFFFF_FFFF, 32'h1);
    @(negedge c_clk);
    resp1(1, 2'd1, 32'h0);
    check("b_fail_vec", chk_fail, 4'b0010);
    check("b_fail_count", fail_count, 1);

    // Port 3: fill the FIFO, overflow it, then drain in order
    for (int i = 0; i < 5; i++) req(2, 4'd5, 32'h1, DW'(i));
    check("c_ovf_vec", chk_ovf, 4'b0100);
    for (int i = 0; i < 4; i++) resp1(2, 2'd1, 32'h1 << i);
    check("c_pass_count", pass_count, 5);
    check("c_busy", busy, 0);

    // Port 4 sub underflow, never answered
    req(3, 4'd2, 32'h3, 32'h5);
    k = 0;
    while (!chk_timeout[3] && k < 100) begin
      @(negedge c_clk);
      k++;
    end
    check("d_tmo_latency", k, 64);
    check("d_tmo_vec", chk_timeout, 4'b1000);
    check("d_fail_count", fail_count, 2);
    check("d_busy", busy, 0);

    // All ports pass together, then saturate the 4-bit counter
    add_all(100);
    check("e_pass_count_4", pass_count, 9);
    add_all(200);
    check("e_pass_count_8", pass_count, 13);
    add_all(300);
    check("e_pass_count_sat", pass_count, 15);

    // Unexpected response on an empty port
    resp1(0, 2'd1, 32'h0);
    check("f_fail_vec", chk_fail, 4'b0001);
    check("f_fail_count", fail_count, 3);

    // Reset with two entries pending on port 2
    req(1, 4'd1, 32'h1, 32'h1);
    req(1, 4'd6, 32'h80, 32'h3);
    check("g_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("g_busy_reset", busy, 0);
    check("g_counts_reset", {pass_count, fail_count, chk_ovf}, 0);
    repeat (3) begin
      @(negedge c_clk);
      check("g_no_pulses", {chk_pass, chk_fail, chk_timeout}, 0);
    end
    reset = 1'b1;
    @(negedge c_clk);

    rand_phase(1500, 25, 40, 1'b1);
    rand_phase(400, 3, 0, 1'b1);
    rand_phase(300, 0, 100, 1'b0);
    repeat (3) @(negedge c_clk);
    for (int p = 0; p < NP; p++) check($sformatf("end_evq_p%0d", p), evq[p].size(), 0);
    check("end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
